// File: rtl/niederreiter_encrypt_if.sv
// Bus bundle for niederreiter_encrypt: request/result handshake plus the public-key memory read port.
// The weight_fail signal exists only when NIEDERREITER_WEIGHT_CHECK_EN is defined.
interface niederreiter_encrypt_if #(
  parameter int m         = 12,
  parameter int t         = 64,
  parameter int N         = 3488,
  parameter int mem_width = 32
);
  localparam int l  = m * t;
  localparam int k  = N - l;
  localparam int W  = (k + mem_width - 1) / mem_width;
  localparam int AW = $clog2(l * W);

  logic                 start;
  logic [N-1:0]         error;
  logic                 busy;
  logic                 done;
  logic [l-1:0]         cipher;
  logic                 PK_rd_en;
  logic [AW-1:0]        PK_rd_addr;
  logic [mem_width-1:0] PK_dout;
`ifdef NIEDERREITER_WEIGHT_CHECK_EN
  logic                 weight_fail;

  modport master (output start, error, PK_dout,
                  input  busy, done, cipher, PK_rd_en, PK_rd_addr, weight_fail);
  modport slave  (input  start, error, PK_dout,
                  output busy, done, cipher, PK_rd_en, PK_rd_addr, weight_fail);
`else
  modport master (output start, error, PK_dout,
                  input  busy, done, cipher, PK_rd_en, PK_rd_addr);
  modport slave  (input  start, error, PK_dout,
                  output busy, done, cipher, PK_rd_en, PK_rd_addr);
`endif
endinterface

// File: rtl/niederreiter_encrypt.sv
// Niederreiter encryption: cipher = [I_l | T]·e over GF(2), with T streamed row-wise from key memory.
// Optional error-weight check enabled by defining NIEDERREITER_WEIGHT_CHECK_EN.
module niederreiter_encrypt #(
  parameter int m         = 12,
  parameter int t         = 64,
  parameter int N         = 3488,
  parameter int mem_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  niederreiter_encrypt_if.slave bus
);
  localparam int l  = m * t;
  localparam int k  = N - l;
  localparam int W  = (k + mem_width - 1) / mem_width;
  localparam int L  = l * W;
  localparam int AW = $clog2(L);
  localparam int RW = (l > 1) ? $clog2(l) : 1;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(W - 1);
  localparam logic [AW-1:0] A_LAST = AW'(L - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic                   accept;
  logic                   rd_en;
  logic                   busy;
  logic                   done;
  logic [N-1:0]           err_q;
  logic [AW-1:0]          addr;
  logic [RW-1:0]          row_cnt;
  logic [WW-1:0]          word_cnt;
  logic                   vld_p1;
  logic [RW-1:0]          row_p1;
  logic [WW-1:0]          word_p1;
  logic                   acc;
  logic [l-1:0]           cipher_q;
  logic [l-1:0]           err_low;
  logic [W*mem_width-1:0] e_tail;
  logic [mem_width-1:0]   e_word;
  logic                   word_par;

  function automatic logic masked_parity(input logic [mem_width-1:0] d,
                                         input logic [mem_width-1:0] e);
    return ^(d & e);
  endfunction

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = READ;
      READ:    if (addr == A_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == READ);
    busy  = (state == READ) || (state == DRAIN);
    done  = (state == DONE);
  end

  // Tail bits beyond k stay zero, so the key's last-word padding never contributes.
  always_comb begin
    e_tail        = '0;
    e_tail[k-1:0] = err_q[N-1:l];
    err_low       = err_q[l-1:0];
    e_word        = '0;
    for (int w = 0; w < W; w++)
      if (word_p1 == WW'(w)) e_word = e_tail[w*mem_width +: mem_width];
    word_par = masked_parity(bus.PK_dout, e_word);
  end

  // Stage p0: address issue; stage p1: key word returns and is folded into the row parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= '0;
      addr     <= '0;
      row_cnt  <= '0;
      word_cnt <= '0;
      vld_p1   <= 1'b0;
      row_p1   <= '0;
      word_p1  <= '0;
      acc      <= 1'b0;
      cipher_q <= '0;
    end else if (accept) begin
      err_q    <= bus.error;
      addr     <= '0;
      row_cnt  <= '0;
      word_cnt <= '0;
      vld_p1   <= 1'b0;
      acc      <= 1'b0;
      cipher_q <= '0;
    end else begin
      vld_p1  <= rd_en;
      row_p1  <= row_cnt;
      word_p1 <= word_cnt;
      if (rd_en && (addr != A_LAST)) begin
        addr <= addr + AW'(1);
        if (word_cnt == W_LAST) begin
          word_cnt <= '0;
          row_cnt  <= row_cnt + RW'(1);
        end else begin
          word_cnt <= word_cnt + WW'(1);
        end
      end
      if (vld_p1) begin
        if (word_p1 == W_LAST) begin
          cipher_q[row_p1] <= acc ^ word_par ^ err_low[row_p1];
          acc              <= 1'b0;
        end else begin
          acc <= acc ^ word_par;
        end
      end
    end
  end

  assign bus.PK_rd_en   = rd_en;
  assign bus.PK_rd_addr = addr;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.cipher     = cipher_q;

`ifdef NIEDERREITER_WEIGHT_CHECK_EN
  localparam int NC = (N + mem_width - 1) / mem_width;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int PW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NC - 1);

  logic [NC*mem_width-1:0] err_pad;
  logic [mem_width-1:0]    chunk;
  logic [CW-1:0]           scan_cnt;
  logic                    scan_act;
  logic [PW-1:0]           popcnt;
  logic                    wfail_q;

  function automatic logic [PW-1:0] popcount(input logic [mem_width-1:0] d);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < mem_width; i++) c = c + PW'(d[i]);
    return c;
  endfunction

  always_comb begin
    err_pad        = '0;
    err_pad[N-1:0] = err_q;
    chunk          = '0;
    for (int c = 0; c < NC; c++)
      if (scan_cnt == CW'(c)) chunk = err_pad[c*mem_width +: mem_width];
  end

  // The scan ends long before DRAIN, so popcnt is final when the verdict is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_act <= 1'b0;
      popcnt   <= '0;
      wfail_q  <= 1'b0;
    end else if (accept) begin
      scan_cnt <= '0;
      scan_act <= 1'b1;
      popcnt   <= '0;
      wfail_q  <= 1'b0;
    end else begin
      if (scan_act) begin
        popcnt <= popcnt + popcount(chunk);
        if (scan_cnt == C_LAST) scan_act <= 1'b0;
        else                    scan_cnt <= scan_cnt + CW'(1);
      end
      if (state == DRAIN) wfail_q <= (popcnt != PW'(t));
    end
  end

  assign bus.weight_fail = wfail_q;
`endif
endmodule

// File: tb/tb_niederreiter_encrypt.sv
// Directed bench for niederreiter_encrypt on a small code (l=8, k=35, 5 key words per row).
module tb_niederreiter_encrypt;
  localparam int TM  = 2;
  localparam int TT  = 4;
  localparam int TN  = 43;
  localparam int TMW = 8;
  localparam int TL  = TM * TT;
  localparam int TK  = TN - TL;
  localparam int TW  = (TK + TMW - 1) / TMW;
  localparam int TLW = TL * TW;
  localparam int TAW = $clog2(TLW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  niederreiter_encrypt_if #(.m(TM), .t(TT), .N(TN), .mem_width(TMW)) bus ();
  niederreiter_encrypt #(.m(TM), .t(TT), .N(TN), .mem_width(TMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Key T[i][j]; row i column j.
  function automatic logic key_bit(input int i, input int j);
    return ((5 * i + 3 * j + i * j) % 7) < 3;
  endfunction

  // Memory word with padding bits driven to 1 so an unmasked tail would corrupt the result.
  function automatic logic [TMW-1:0] mem_word(input int a);
    logic [TMW-1:0] d;
    int row, w, j;
    row = a / TW;
    w   = a % TW;
    for (int b = 0; b < TMW; b++) begin
      j    = w * TMW + b;
      d[b] = (j < TK) ? key_bit(row, j) : 1'b1;
    end
    return d;
  endfunction

  function automatic logic [TL-1:0] ref_cipher(input logic [TN-1:0] e);
    logic [TL-1:0] c;
    for (int i = 0; i < TL; i++) begin
      c[i] = e[i];
      for (int j = 0; j < TK; j++) c[i] = c[i] ^ (key_bit(i, j) & e[TL + j]);
    end
    return c;
  endfunction

  initial bus.PK_dout = '0;
  always @(posedge clk)
    if (bus.PK_rd_en) bus.PK_dout <= mem_word(int'(bus.PK_rd_addr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one encryption from IDLE; optional extra start pulses at cycles s1/s2 carrying err_alt.
  task automatic run_enc(input logic [TN-1:0] e, input int s1, input int s2,
                         input logic [TN-1:0] err_alt,
                         output int lat, output int rd_cnt, output int done_cnt,
                         output int addr_bad, output logic [TL-1:0] c1_cipher);
    lat = -1; rd_cnt = 0; done_cnt = 0; addr_bad = 0; c1_cipher = '0;
    @(negedge clk);
    bus.error = e;
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) c1_cipher = bus.cipher;
      if (bus.PK_rd_en) begin
        if (bus.PK_rd_addr != TAW'(rd_cnt)) addr_bad++;
        rd_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) lat = c;
      end
      if (c == s1 || c == s2) begin
        bus.start = 1'b1;
        bus.error = err_alt;
      end else begin
        bus.start = 1'b0;
      end
      if (lat >= 0 && c >= lat + 6) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic [TN-1:0] err;
    logic [TL-1:0] exp;
  } vec_t;

  initial begin
    vec_t           vecs[8];
    logic [TN-1:0]  e;
    logic [TL-1:0]  c1;
    int             lat, rdc, dc, ab;

    e = '0;                                vecs[0] = '{"zero",     e, 8'h00};
    e = '0; e[5] = 1'b1;                   vecs[1] = '{"bit5",     e, 8'h20};
    e = '0; e[TL+10] = 1'b1;               vecs[2] = '{"col10",    e, 8'hE1};
    e = '0; e[TN-1] = 1'b1;                vecs[3] = '{"col_last", e, 8'h4A};
    e = '0; e[5] = 1'b1; e[TL+10] = 1'b1; e[TN-1] = 1'b1;
                                           vecs[4] = '{"mix3",     e, 8'h8B};
    e = '0; e[1] = 1'b1; e[12] = 1'b1; e[25] = 1'b1; e[39] = 1'b1;
                                           vecs[5] = '{"wt4",      e, ref_cipher(e)};
    e = '1;                                vecs[6] = '{"all_ones", e, ref_cipher(e)};
    e = '0; e[7:0] = 8'hFF;                vecs[7] = '{"low_ff",   e, 8'hFF};

    bus.start = 1'b0;
    bus.error = '0;
    repeat (3) @(negedge clk);
    check("rst_cipher", bus.cipher, 0);
    check("rst_busy",   bus.busy, 0);
    check("rst_done",   bus.done, 0);
    check("rst_rd_en",  bus.PK_rd_en, 0);
    check("rst_addr",   bus.PK_rd_addr, 0);
`ifdef NIEDERREITER_WEIGHT_CHECK_EN
    check("rst_wfail",  bus.weight_fail, 0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_enc(vecs[v].err, 0, 0, '0, lat, rdc, dc, ab, c1);
      check({vecs[v].name, "_cipher"}, bus.cipher, vecs[v].exp);
      check({vecs[v].name, "_latency"}, lat, TLW + 2);
      check({vecs[v].name, "_rd_cycles"}, rdc, TLW);
      check({vecs[v].name, "_addr_seq"}, ab, 0);
      check({vecs[v].name, "_done_pulses"}, dc, 1);
`ifdef NIEDERREITER_WEIGHT_CHECK_EN
      check({vecs[v].name, "_wfail"}, bus.weight_fail, ($countones(vecs[v].err) != TT));
`endif
    end
    check("addr_hold", bus.PK_rd_addr, TLW - 1);
    check("idle_busy", bus.busy, 0);

    // Extra starts mid-run (different error) and one on the done cycle are all ignored.
    e = '1;
    run_enc(vecs[4].err, 10, 30, e, lat, rdc, dc, ab, c1);
    check("restart_c1_clear", c1, 0);
    check("restart_cipher", bus.cipher, 8'h8B);
    check("restart_done_pulses", dc, 1);
    run_enc(vecs[2].err, TLW + 2, 0, e, lat, rdc, dc, ab, c1);
    check("start_on_done_cipher", bus.cipher, 8'hE1);
    check("start_on_done_busy", bus.busy, 0);
    check("start_on_done_pulses", dc, 1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.error = vecs[7].err;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_partial_cipher", (bus.cipher != 0), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cipher", bus.cipher, 0);
    check("mid_rst_busy",   bus.busy, 0);
    check("mid_rst_rd_en",  bus.PK_rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) dc++;
      @(negedge clk);
    end
    check("mid_rst_no_done", dc, 0);
    run_enc(vecs[5].err, 0, 0, '0, lat, rdc, dc, ab, c1);
    check("after_rst_cipher", bus.cipher, vecs[5].exp);
    check("after_rst_latency", lat, TLW + 2);

`ifdef NIEDERREITER_WEIGHT_CHECK_EN
    e = '0; e[0] = 1'b1; e[20] = 1'b1; e[42] = 1'b1;
    run_enc(e, 0, 0, '0, lat, rdc, dc, ab, c1);
    check("wt3_wfail", bus.weight_fail, 1);
    check("wt3_cipher", bus.cipher, ref_cipher(e));
    e = '0; e[0] = 1'b1; e[9] = 1'b1; e[20] = 1'b1; e[33] = 1'b1; e[42] = 1'b1;
    run_enc(e, 0, 0, '0, lat, rdc, dc, ab, c1);
    check("wt5_wfail", bus.weight_fail, 1);
    e = '0; e[3] = 1'b1; e[17] = 1'b1; e[30] = 1'b1; e[41] = 1'b1;
    run_enc(e, 0, 0, '0, lat, rdc, dc, ab, c1);
    check("wt4_wfail", bus.weight_fail, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/niederreiter_encrypt.md
Name: niederreiter_encrypt

Overview:
- Encryption-side counterpart of the decryption datapath: computes the Niederreiter ciphertext (syndrome) c = [I_l | T]·e over GF(2).
- Inputs are a weight-t error vector e (N bits) and the systematic public key T (l×k, l = m·t, k = N − l).
- T is streamed row-wise from an external synchronous dual-port memory loaded with the public-key file.
- The resulting cipher has the same l-bit format consumed by the decryption block, so one bench can run encrypt→decrypt loopback.

Parameters:
- m, 12: GF(2^m) field width.
- t, 64: error-correcting capability / required error weight.
- N, 3488: code length.
- mem_width, 32: public-key memory word width in bits.
- Derived (localparam): l = m·t = 768; k = N − l = 2720; W = ceil(k/mem_width) = 85 words per row; AW = clog2(l·W) address width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: one-cycle request; sampled only in IDLE.
- error, input, N: error vector; latched internally on the accepted start.
- PK_rd_en, output, 1: public-key memory read enable.
- PK_rd_addr, output, AW: word address = row·W + word.
- PK_dout, input, mem_width: read data, valid one cycle after PK_rd_en/PK_rd_addr.
- cipher, output, l: ciphertext; bit i = row i.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse when cipher is final.

Behaviour:
- Reset values: cipher=0, done=0, busy=0, PK_rd_en=0, PK_rd_addr=0, FSM=IDLE, counters=0, latched error=0.
- Reset is honoured at any time, including mid-operation: the block aborts, returns to IDLE and clears cipher; no done is issued for the aborted run.
- FSM states:
  - IDLE: on start=1, latch error, clear the accumulator, go to READ.
  - READ: issue one read per cycle. Addresses run 0 .. l·W−1 in order: row-major, word w fastest.
  - DRAIN: one cycle to absorb the last read response.
  - DONE: pulse done, return to IDLE.
- Accumulation: on the cycle PK_dout is valid for (row i, word w), acc ^= ^(PK_dout & e_tail[w·mem_width +: mem_width]), where e_tail = error[N−1:l].
  - Bit b of word w pairs with error bit l + w·mem_width + b.
- Row end: at w = W−1, cipher[i] <= acc ^ error[i] and acc clears.
  - This happens in the same cycle the word arrives, so back-to-back rows need no bubble.
- Padding: error-tail bits with index ≥ k are forced to 0 inside the block. The memory's last-word padding bits are therefore don't-care.
- Latency: the start-sampling edge is cycle 0.
  - Reads are issued in cycles 1..l·W.
  - done is high in cycle l·W+2, i.e. 65282 cycles for the defaults.
  - busy falls together with done.
- Output hold: cipher holds its final value until the next accepted start; it clears to 0 on that start.
- Handshake: start while busy is ignored, with no effect on the current run. start in the same cycle as done is also ignored; it is accepted from the next IDLE cycle.
- The error input may change freely after the accepted start.
- PK_rd_en is high exactly for the l·W read cycles and low otherwise. PK_rd_addr holds its last value when idle.

Optional Feature:
- Macro: NIEDERREITER_WEIGHT_CHECK_EN.
- When defined:
  - Adds output port weight_fail (1 bit, reset 0).
  - A side counter scans the latched error in mem_width-bit chunks, one chunk per cycle, starting at cycle 1. It takes ceil(N/mem_width) = 109 cycles, well inside the READ phase.
  - A popcount is accumulated into a clog2(N+1)-bit register.
  - At done, weight_fail = (popcount ≠ t). It is held until the next accepted start, then cleared.
  - Cipher is still computed normally when weight_fail is set.
- When undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- error=0, public key from file → done at cycle 65282 after start; cipher = 0; PK_rd_en high for exactly 65280 cycles.
- error with a single bit 5 (< l) → cipher has only bit 5 set, regardless of public-key contents.
- error with a single bit l+100, on a key whose column 100 is known → cipher equals T column 100. Also repeat with bit N−1 to exercise the last-word padding mask.
- Random weight-64 error against a golden cipher file → bit-exact match. Loopback into decryption gives error_recovered == error with decryption_fail=0.
- start pulsed again at cycles 10 and 30000 of a run → ignored; exactly one done; cipher matches the first run's error.
- rst at cycle 1000 mid-run → cipher=0, busy=0, no done pulse; a following start completes correctly.
- With NIEDERREITER_WEIGHT_CHECK_EN defined: weight 64 → weight_fail=0; weight 63 and weight 65 → weight_fail=1 at done.
